fetch_next_pc_predictor: RTL and testbench

//  Next-generation PC-input selection. Owns the fetch PC register and predicts the next PC

---
 rtl/fetch_next_pc_predictor.sv | 222 ++++++++++++++++++++++
 tb/tb_fetch_next_pc_predictor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_next_pc_predictor.sv
// fetch_next_pc_predictor
//   Owns the fetch PC and predicts the next fetch address from a direct-mapped
//   branch target buffer (BTB). Each BTB entry holds a valid bit, a tag, a
//   target and a 2-bit saturating counter. Resolved control flow from execute
//   trains the table. A wrong carried prediction raises a same-cycle redirect.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   stall              hold fetch_pc (a redirect still wins)
//   fetch_pc           current fetch PC
//   pred_taken         table predicts taken for fetch_pc (combinational)
//   pred_target        predicted next PC for fetch_pc
//   res_*              resolution bundle from execute
//   mispredict         redirect this cycle, younger instructions must flush
//   redirect_pc        correct next PC (meaningful while mispredict is high)

package fetch_next_pc_predictor_pkg;
  typedef enum logic [6:0] {
    OPCODE_LOAD   = 7'b0000011,
    OPCODE_OP_IMM = 7'b0010011,
    OPCODE_STORE  = 7'b0100011,
    OPCODE_OP     = 7'b0110011,
    OPCODE_LUI    = 7'b0110111,
    OPCODE_BRANCH = 7'b1100011,
    OPCODE_JALR   = 7'b1100111,
    OPCODE_JAL    = 7'b1101111
  } opcode_t;
endpackage

module fetch_next_pc_predictor
  import fetch_next_pc_predictor_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0]  RESET_PC    = {XLEN{1'b0}},
  parameter bit               PREDICT_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  output logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  opcode_t         res_opcode,
  input  logic            res_branch_result,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - IDXW - 2;
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  // Saturating counter helpers: 2'b11 and 2'b00 are sticky.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : (c + 2'b01);
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : (c - 2'b01);
  endfunction

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            valid_q  [BTB_ENTRIES];
  logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0] target_q [BTB_ENTRIES];
  logic [1:0]      ctr_q    [BTB_ENTRIES];

  // The carried taken bit is redundant with the carried target for redirect
  // purposes; only the target comparison decides a mispredict.
  logic unused_s;
  assign unused_s = res_pred_taken;

  // Lookup side.
  logic [IDXW-1:0] f_idx_s;
  logic [TAGW-1:0] f_tag_s;
  logic            f_hit_s;
  logic            pred_taken_s;
  logic [XLEN-1:0] pred_target_s;

  assign f_idx_s       = fetch_pc_q[IDXW+1:2];
  assign f_tag_s       = fetch_pc_q[XLEN-1:IDXW+2];
  assign f_hit_s       = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
  assign pred_taken_s  = PREDICT_EN && f_hit_s && ctr_q[f_idx_s][1];
  assign pred_target_s = pred_taken_s ? target_q[f_idx_s] : (fetch_pc_q + PC_STEP);

  // Resolution side.
  logic [IDXW-1:0] r_idx_s;
  logic [TAGW-1:0] r_tag_s;
  logic            r_hit_s;
  logic            is_ctrl_s;
  logic            is_jump_s;
  logic            taken_s;
  logic [XLEN-1:0] correct_pc_s;
  logic            mispredict_s;

  assign r_idx_s = res_pc[IDXW+1:2];
  assign r_tag_s = res_pc[XLEN-1:IDXW+2];
  assign r_hit_s = valid_q[r_idx_s] && (tag_q[r_idx_s] == r_tag_s);

  // Decode actual control-flow outcome from the resolving opcode.
  always_comb begin
    is_ctrl_s = 1'b0;
    is_jump_s = 1'b0;
    taken_s   = 1'b0;
    case (res_opcode)
      OPCODE_BRANCH: begin
        is_ctrl_s = 1'b1;
        taken_s   = res_branch_result;
      end
      OPCODE_JAL, OPCODE_JALR: begin
        is_ctrl_s = 1'b1;
        is_jump_s = 1'b1;
        taken_s   = 1'b1;
      end
      default: begin
        is_ctrl_s = 1'b0;
        is_jump_s = 1'b0;
        taken_s   = 1'b0;
      end
    endcase
  end

  assign correct_pc_s = taken_s ? res_target : (res_pc + PC_STEP);
  // Suppressed during reset so no redirect escapes while state is discarded.
  assign mispredict_s = res_valid && !reset && (res_pred_target != correct_pc_s);

  // Next fetch PC: redirect beats stall, stall beats prediction.
  always_comb begin
    fetch_pc_d = pred_target_s;
    if (mispredict_s) begin
      fetch_pc_d = correct_pc_s;
    end else if (stall) begin
      fetch_pc_d = fetch_pc_q;
    end else begin
      fetch_pc_d = pred_target_s;
    end
  end

  // Training write for the entry addressed by res_pc.
  logic            wr_en_s;
  logic            wr_valid_s;
  logic [XLEN-1:0] wr_target_s;
  logic [1:0]      wr_ctr_s;

  // Compute the BTB update from the resolution bundle.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_valid_s  = valid_q[r_idx_s];
    wr_target_s = target_q[r_idx_s];
    wr_ctr_s    = ctr_q[r_idx_s];
    if (res_valid) begin
      if (is_ctrl_s && r_hit_s) begin
        wr_en_s = 1'b1;
        if (is_jump_s) begin
          wr_ctr_s = 2'b11;
        end else if (taken_s) begin
          wr_ctr_s = ctr_inc(ctr_q[r_idx_s]);
        end else begin
          wr_ctr_s = ctr_dec(ctr_q[r_idx_s]);
        end
        if (taken_s) begin
          wr_target_s = res_target;
        end else begin
          wr_target_s = target_q[r_idx_s];
        end
      end else if (is_ctrl_s && taken_s) begin
        // Allocate on a taken miss; jumps start strongly taken.
        wr_en_s     = 1'b1;
        wr_valid_s  = 1'b1;
        wr_target_s = res_target;
        wr_ctr_s    = is_jump_s ? 2'b11 : 2'b10;
      end else if (!is_ctrl_s && r_hit_s) begin
        // Non-control instruction aliases a live entry: drop it.
        wr_en_s    = 1'b1;
        wr_valid_s = 1'b0;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // BTB storage; reset wins over a same-cycle training write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= {TAGW{1'b0}};
        target_q[i] <= {XLEN{1'b0}};
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en_s) begin
      valid_q[r_idx_s]  <= wr_valid_s;
      tag_q[r_idx_s]    <= r_tag_s;
      target_q[r_idx_s] <= wr_target_s;
      ctr_q[r_idx_s]    <= wr_ctr_s;
    end
  end

  assign fetch_pc    = fetch_pc_q;
  assign pred_taken  = pred_taken_s;
  assign pred_target = pred_target_s;
  assign mispredict  = mispredict_s;
  assign redirect_pc = correct_pc_s;

endmodule

// File: tb/tb_fetch_next_pc_predictor.sv
// Bench for fetch_next_pc_predictor: two instances (prediction on / off) share
// one stimulus stream and are compared against a behavioural BTB model.
module tb_fetch_next_pc_predictor;
  import fetch_next_pc_predictor_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, stall = 1'b0;
  logic        res_valid = 1'b0, res_branch_result = 1'b0, res_pred_taken = 1'b0;
  logic [31:0] res_pc = 32'h0, res_target = 32'h0, res_pred_target = 32'h0;
  opcode_t     res_opcode = OPCODE_OP;

  logic [31:0] fpc0, ptg0, rd0, fpc1, ptg1, rd1;
  logic        pt0, mp0, pt1, mp1;

  fetch_next_pc_predictor #(.PREDICT_EN(1'b1)) dut_pred (
    .clk(clk), .reset(reset), .stall(stall),
    .fetch_pc(fpc0), .pred_taken(pt0), .pred_target(ptg0),
    .res_valid(res_valid), .res_pc(res_pc), .res_opcode(res_opcode),
    .res_branch_result(res_branch_result), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .mispredict(mp0), .redirect_pc(rd0));

  fetch_next_pc_predictor #(.PREDICT_EN(1'b0)) dut_static (
    .clk(clk), .reset(reset), .stall(stall),
    .fetch_pc(fpc1), .pred_taken(pt1), .pred_target(ptg1),
    .res_valid(res_valid), .res_pc(res_pc), .res_opcode(res_opcode),
    .res_branch_result(res_branch_result), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .mispredict(mp1), .redirect_pc(rd1));

  typedef struct {
    bit          v;
    int unsigned tag;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  ent_t        btb [2][16];
  logic [31:0] mpc [2];
  int          n_vec = 0;
  int          n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input opcode_t op, input bit br);
    if (op == OPCODE_BRANCH) return br;
    if (op == OPCODE_JAL || op == OPCODE_JALR) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_correct(input logic [31:0] pc, input opcode_t op,
                                              input bit br, input logic [31:0] tgt);
    return ref_taken(op, br) ? tgt : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mpc[d] = 32'h0;
      for (int i = 0; i < 16; i++) begin
        btb[d][i].v = 1'b0; btb[d][i].tag = 0; btb[d][i].tgt = 32'h0; btb[d][i].ctr = 1;
      end
    end
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  // One cycle: drive at negedge, check outputs, then advance the model.
  task automatic step(input bit rst, input bit stl, input bit rv, input logic [31:0] rpc,
                      input opcode_t rop, input bit rbr, input logic [31:0] rtgt,
                      input bit rpt, input logic [31:0] rptgt);
    logic [31:0] corr, ptg, o_fpc, o_ptg, o_rd;
    logic        o_pt, o_mp;
    bit          mp, hit, ptk, rhit, ctrl, jump, tk;
    int unsigned fi, ft, ri, rt;
    @(negedge clk);
    reset = rst; stall = stl; res_valid = rv; res_pc = rpc; res_opcode = rop;
    res_branch_result = rbr; res_target = rtgt; res_pred_taken = rpt; res_pred_target = rptgt;
    #1;
    corr = ref_correct(rpc, rop, rbr, rtgt);
    tk   = ref_taken(rop, rbr);
    mp   = rv && !rst && (rptgt != corr);
    ctrl = (rop == OPCODE_BRANCH) || (rop == OPCODE_JAL) || (rop == OPCODE_JALR);
    jump = (rop == OPCODE_JAL) || (rop == OPCODE_JALR);
    ri   = (rpc / 4) % 16;
    rt   = rpc / 64;
    for (int d = 0; d < 2; d++) begin
      o_fpc = (d == 0) ? fpc0 : fpc1;
      o_pt  = (d == 0) ? pt0  : pt1;
      o_ptg = (d == 0) ? ptg0 : ptg1;
      o_mp  = (d == 0) ? mp0  : mp1;
      o_rd  = (d == 0) ? rd0  : rd1;
      fi  = (mpc[d] / 4) % 16;
      ft  = mpc[d] / 64;
      hit = btb[d][fi].v && (btb[d][fi].tag == ft);
      ptk = (d == 0) && hit && (btb[d][fi].ctr >= 2);
      ptg = ptk ? btb[d][fi].tgt : mpc[d] + 32'd4;
      check($sformatf("fetch_pc[%0d]", d), o_fpc, mpc[d]);
      check($sformatf("pred_taken[%0d]", d), 32'(o_pt), 32'(ptk));
      check($sformatf("pred_target[%0d]", d), o_ptg, ptg);
      check($sformatf("mispredict[%0d]", d), 32'(o_mp), 32'(mp));
      if (mp) check($sformatf("redirect_pc[%0d]", d), o_rd, corr);
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          btb[d][i].v = 1'b0; btb[d][i].ctr = 1;
        end
        mpc[d] = 32'h0;
      end else begin
        if (rv) begin
          rhit = btb[d][ri].v && (btb[d][ri].tag == rt);
          if (ctrl && rhit) begin
            if (jump) btb[d][ri].ctr = 3;
            else if (tk) btb[d][ri].ctr = (btb[d][ri].ctr == 3) ? 3 : btb[d][ri].ctr + 1;
            else btb[d][ri].ctr = (btb[d][ri].ctr == 0) ? 0 : btb[d][ri].ctr - 1;
            if (tk) btb[d][ri].tgt = rtgt;
          end else if (ctrl && tk) begin
            btb[d][ri].v = 1'b1; btb[d][ri].tag = rt; btb[d][ri].tgt = rtgt;
            btb[d][ri].ctr = jump ? 3 : 2;
          end else if (!ctrl && rhit) begin
            btb[d][ri].v = 1'b0;
          end
        end
        if (mp) mpc[d] = corr;
        else if (!stl) mpc[d] = ptg;
      end
    end
  endtask

  task automatic idle(input bit stl);
    step(1'b0, stl, 1'b0, 32'h0, OPCODE_OP, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Steer fetch to pc via a non-control resolution at pc-4 carrying a bad target.
  task automatic steer(input logic [31:0] pc);
    step(1'b0, 1'b0, 1'b1, pc - 32'd4, OPCODE_OP, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFF0);
  endtask

  opcode_t ops [6] = '{OPCODE_BRANCH, OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR, OPCODE_OP, OPCODE_LOAD};

  initial begin
    logic [31:0] rpc, rtgt, rptgt;
    opcode_t     rop;
    bit          rbr;
    hard_reset();

    // Sequential fetch after reset, nothing predicted.
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      check("t1_pc", fpc0, 32'(i * 4));
      check("t1_taken", 32'(pt0), 32'h0);
    end

    // Branch at 0x10 resolves taken to 0x40.
    step(1'b0, 1'b0, 1'b1, 32'h10, OPCODE_BRANCH, 1'b1, 32'h40, 1'b0, 32'h14);
    check("t2_mispredict", 32'(mp0), 32'h1);
    check("t2_redirect", rd0, 32'h40);
    steer(32'h10);
    idle(1'b0);
    check("t2_pred_target", ptg0, 32'h40);
    check("t6_static_taken", 32'(pt1), 32'h0);
    check("t6_static_target", ptg1, 32'h14);

    // Two not-taken resolutions: 2 -> 1 -> 0.
    step(1'b0, 1'b0, 1'b1, 32'h10, OPCODE_BRANCH, 1'b0, 32'h40, 1'b1, 32'h40);
    check("t3_redirect", rd0, 32'h14);
    step(1'b0, 1'b0, 1'b1, 32'h10, OPCODE_BRANCH, 1'b0, 32'h40, 1'b0, 32'h14);
    check("t3_no_mispredict", 32'(mp0), 32'h0);
    steer(32'h10);
    idle(1'b0);
    check("t3_pred_target", ptg0, 32'h14);

    // JAL redirect overrides stall.
    step(1'b0, 1'b1, 1'b1, 32'h20, OPCODE_JAL, 1'b0, 32'h100, 1'b0, 32'h24);
    idle(1'b1);
    check("t4_fetch_pc", fpc0, 32'h100);

    // Non-control alias of the JAL entry.
    step(1'b0, 1'b0, 1'b1, 32'h20, OPCODE_OP, 1'b0, 32'h100, 1'b1, 32'h100);
    check("t5_redirect", rd0, 32'h24);
    steer(32'h20);
    idle(1'b0);
    check("t5_invalidated", 32'(pt0), 32'h0);

    // Reset discards a same-cycle resolution (JAL @0x8 would predict taken).
    step(1'b1, 1'b0, 1'b1, 32'h8, OPCODE_JAL, 1'b0, 32'h80, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) idle(1'b0);
    check("t6_reset_pc", fpc0, 32'h8);
    check("t6_reset_table", 32'(pt0), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      rpc  = 32'($urandom_range(0, 127)) << 2;
      rtgt = 32'($urandom_range(0, 127)) << 2;
      rop  = ops[$urandom_range(0, 5)];
      rbr  = 1'($urandom_range(0, 1));
      rptgt = ($urandom_range(0, 1) != 0) ? ref_correct(rpc, rop, rbr, rtgt)
                                         : (32'($urandom_range(0, 127)) << 2);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0), rpc, rop, rbr, rtgt,
           1'($urandom_range(0, 1)), rptgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
